// File: rtl/tts_gfx_pkg.sv
// Shared graphics-subsystem constants: default ROM geometry, requester indices
// and the sprite ROM arbiter state encoding.
package tts_gfx_pkg;

  localparam int ROM_LAT = 2;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 12;

  localparam int REQ_PLAYER = 0;
  localparam int REQ_ENEMY  = 1;
  localparam int REQ_BG     = 2;
  localparam int REQ_HUD    = 3;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// searching upward and wrapping back to index 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter for the shared sprite ROM read port with burst lock and
// ID-tagged fixed-latency return. Define BLANK_ONLY_EN to grant only during blanking.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = tts_gfx_pkg::ADDR_W,
  parameter int DATA_W    = tts_gfx_pkg::DATA_W,
  parameter int ROM_LAT   = tts_gfx_pkg::ROM_LAT,
  parameter int MAX_BURST = 8
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  input  logic                        video_enable,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        rom_en,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_data,
  output logic                        rd_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rd_id,
  output logic [DATA_W-1:0]           rd_data
);
  import tts_gfx_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [CNT_W-1:0]   burst, burst_n;
  logic               grant_ok;
  logic [IDX_W-1:0]   grant_id;
  logic [NUM_REQ-1:0] gnt_n;
  logic               allow;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [IDX_W-1:0]   gnt_id_p0;
  logic               vld_p [ROM_LAT];
  logic [IDX_W-1:0]   id_p  [ROM_LAT];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

`ifdef BLANK_ONLY_EN
  assign allow = ~video_enable;
`else
  logic unused_video_enable;
  assign unused_video_enable = video_enable;
  assign allow = 1'b1;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
      burst <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      burst <= burst_n;
    end
  end

  // Exit from LOCK is checked before re-granting, so the exit cycle issues nothing.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    owner_n  = owner;
    burst_n  = burst;
    grant_ok = 1'b0;
    grant_id = pick_idx;
    gnt_n    = '0;
    case (state)
      ARB: begin
        if (pick_any && allow) begin
          grant_ok = 1'b1;
          grant_id = pick_idx;
          gnt_n    = pick_onehot;
          ptr_n    = next_idx(pick_idx);
          if (req_lock[pick_idx]) begin
            state_n = LOCK;
            owner_n = pick_idx;
            burst_n = CNT_W'(1);
          end
        end
      end
      LOCK: begin
        if (!req[owner] || !req_lock[owner] ||
            (burst == CNT_W'(MAX_BURST)) || !allow) begin
          state_n = ARB;
          ptr_n   = next_idx(owner);
          burst_n = '0;
        end else begin
          grant_ok     = 1'b1;
          grant_id     = owner;
          gnt_n[owner] = 1'b1;
          burst_n      = burst + 1'b1;
        end
      end
      default: state_n = ARB;
    endcase
  end

  // Stage p0: registered grant, ROM strobe and address
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      gnt_id_p0 <= '0;
    end else begin
      gnt       <= gnt_n;
      rom_en    <= grant_ok;
      gnt_id_p0 <= grant_id;
      if (grant_ok) rom_addr <= req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    end
  end

  // Tag pipeline: ROM_LAT stages, last stage lines up with rom_data
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        vld_p[k] <= 1'b0;
        id_p[k]  <= '0;
      end
    end else begin
      vld_p[0] <= rom_en;
      id_p[0]  <= gnt_id_p0;
      for (int k = 1; k < ROM_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        id_p[k]  <= id_p[k-1];
      end
    end
  end

  // Return stage: registered copy of ROM data with its owner tag
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= vld_p[ROM_LAT-1];
      if (vld_p[ROM_LAT-1]) begin
        rd_id   <= id_p[ROM_LAT-1];
        rd_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus random
// traffic against a behavioural grant/return model and a latency-modelled ROM.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 12;
  localparam int ROM_LAT   = 2;
  localparam int MAX_BURST = 8;
  localparam int IDX_W     = $clog2(NUM_REQ);

  logic                       pixel_clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       video_enable = 1'b0;
  logic [NUM_REQ-1:0]         req = '0;
  logic [NUM_REQ-1:0]         req_lock = '0;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
  logic [NUM_REQ-1:0]         gnt;
  logic                       rom_en;
  logic [ADDR_W-1:0]          rom_addr;
  logic [DATA_W-1:0]          rom_data;
  logic                       rd_valid;
  logic [IDX_W-1:0]           rd_id;
  logic [DATA_W-1:0]          rd_data;

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ROM_LAT(ROM_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .pixel_clk    (pixel_clk),
    .reset        (reset),
    .video_enable (video_enable),
    .req          (req),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .gnt          (gnt),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .rd_valid     (rd_valid),
    .rd_id        (rd_id),
    .rd_data      (rd_data)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    if (a == 10'h05A) return 12'hF00;
    return ({2'b00, a} * 12'd7) ^ 12'h3C5;
  endfunction

  // Synchronous ROM with ROM_LAT cycles from rom_en to data
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge pixel_clk) begin
    rom_pipe[0] <= rom_en ? rom_f(rom_addr) : 12'h000;
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  typedef struct {
    int              due;
    int              id;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              exp_q[$];
  int                m_ptr = 0;
  int                m_owner = -1;
  int                m_burst = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_bad = 0;

  int                seen_n = 0;
  int                seen_id [32];
  int                seen_cyc [32];
  logic [DATA_W-1:0] seen_data [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_owner = -1;
    m_burst = 0;
    m_addr = '0;
    exp_q.delete();
  endtask

  // Grant decision from the rules: lock owner keeps the port until a drop,
  // an unlock, a full burst or (blank-only build) active video; otherwise round robin.
  task automatic model_decide(output int w);
    bit blocked;
    w = -1;
`ifdef BLANK_ONLY_EN
    blocked = video_enable;
`else
    blocked = 1'b0;
`endif
    if (m_owner >= 0) begin
      if (!req[m_owner] || !req_lock[m_owner] || m_burst >= MAX_BURST || blocked) begin
        m_ptr = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end else begin
        w = m_owner;
        m_burst++;
      end
    end else if (!blocked) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req[j]) w = j;
      end
      if (w >= 0) begin
        m_ptr = (w + 1) % NUM_REQ;
        if (req_lock[w]) begin
          m_owner = w;
          m_burst = 1;
        end
      end
    end
  endtask

  task automatic tick();
    int w;
    ret_t r;
    logic [NUM_REQ-1:0] eg;
    w = -1;
    if (!reset) model_decide(w);
    @(posedge pixel_clk);
    #1;
    cyc++;
    eg = '0;
    if (reset) begin
      model_reset();
    end else if (w >= 0) begin
      eg[w]  = 1'b1;
      m_addr = req_addr[w*ADDR_W +: ADDR_W];
      r.due  = cyc + ROM_LAT + 1;
      r.id   = w;
      r.data = rom_f(m_addr);
      exp_q.push_back(r);
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rom_en", 32'(rom_en), 32'(w >= 0));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_id", 32'(rd_id), 32'(exp_q[0].id));
      chk("rd_data", 32'(rd_data), 32'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    end
    if (rd_valid === 1'b1 && seen_n < 32) begin
      seen_id[seen_n]   = int'(rd_id);
      seen_cyc[seen_n]  = cyc;
      seen_data[seen_n] = rd_data;
      seen_n++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int g_cyc;

    // 1: reset held with all requests pending, then plain round robin
    req = 4'b1111;
    ticks(3);
    chk("t1_rst_gnt", 32'(gnt), 32'd0);
    reset = 1'b0;
    tick(); chk("t1_g0", 32'(gnt), 32'b0001);
    tick(); chk("t1_g1", 32'(gnt), 32'b0010);
    tick(); chk("t1_g2", 32'(gnt), 32'b0100);
    tick(); chk("t1_g3", 32'(gnt), 32'b1000);
    tick(); chk("t1_g4", 32'(gnt), 32'b0001);
    req = '0;
    ticks(5);

    // 2: single read from requester 2
    req_addr[2*ADDR_W +: ADDR_W] = 10'h05A;
    req = 4'b0100;
    seen_n = 0;
    tick();
    g_cyc = cyc;
    chk("t2_gnt", 32'(gnt), 32'b0100);
    chk("t2_addr", 32'(rom_addr), 32'h05A);
    req = '0;
    ticks(6);
    chk("t2_count", 32'(seen_n), 32'd1);
    chk("t2_lat", 32'(seen_cyc[0] - g_cyc), 32'(ROM_LAT + 1));
    chk("t2_id", 32'(seen_id[0]), 32'd2);
    chk("t2_data", 32'(seen_data[0]), 32'hF00);

    // 3: locked burst on requester 1 with requester 0 waiting
    req = 4'b0001;
    tick();
    req = 4'b0011;
    req_lock = 4'b0010;
    for (int i = 0; i < MAX_BURST; i++) begin
      tick();
      chk("t3_burst", 32'(gnt), 32'b0010);
    end
    tick(); chk("t3_exit_idle", 32'(gnt), 32'd0);
    tick(); chk("t3_after", 32'(gnt), 32'b0001);
    req = '0;
    req_lock = '0;
    ticks(5);

    // 4: alternating single requesters, back-to-back returns
    seen_n = 0;
    for (int i = 0; i < 6; i++) begin
      req = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      tick();
    end
    req = '0;
    ticks(5);
    chk("t4_count", 32'(seen_n), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t4_id", 32'(seen_id[i]), (i % 2 == 0) ? 32'd0 : 32'd3);
      chk("t4_gap", 32'(seen_cyc[i] - seen_cyc[0]), 32'(i));
    end

    // 5: reset one cycle after a grant drops the in-flight read
    req = 4'b0100;
    tick();
    chk("t5_gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    reset = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_en", 32'(rom_en), 32'd0);
    chk("t5_rst_addr", 32'(rom_addr), 32'd0);
    chk("t5_rst_vld", 32'(rd_valid), 32'd0);
    chk("t5_rst_id", 32'(rd_id), 32'd0);
    chk("t5_rst_data", 32'(rd_data), 32'd0);
    model_reset();
    seen_n = 0;
    ticks(2);
    reset = 1'b0;
    ticks(6);
    chk("t5_no_return", 32'(seen_n), 32'd0);

    // 6: request during active video
    video_enable = 1'b1;
    req = 4'b0001;
`ifdef BLANK_ONLY_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_blocked", 32'(gnt), 32'd0);
    end
    video_enable = 1'b0;
    tick();
    chk("t6_blank_gnt", 32'(gnt), 32'b0001);
`else
    tick();
    chk("t6_gnt", 32'(gnt), 32'b0001);
`endif
    req = '0;
    video_enable = 1'b0;
    ticks(5);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      req = NUM_REQ'($urandom());
      req_lock = NUM_REQ'($urandom()) & NUM_REQ'($urandom());
      video_enable = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      tick();
    end
    req = '0;
    req_lock = '0;
    video_enable = 1'b0;
    ticks(ROM_LAT + 4);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
